pwm_fade_sequencer: RTL

Round-robin fade controller for the board's three status LEDs. It owns one free-running 8-bit PWM counter and a brightness register per channel. A sequencer FSM fades one channel at a time through ramp-up, hold, ramp-down, then moves to the next channel, giving a chaser effect. It replaces per-LED free-running fade logic at the top level and is driven by a single enable.

---
 rtl/pwm_fade_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_fade_sequencer                                           |
// | Description : Round-robin ramp/hold/ramp fader for three PWM status LEDs.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_fade_sequencer #(
  parameter int STEP_DIV   = 1_500_000,
  parameter int STEP       = 5,
  parameter int HOLD_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] led,
  output logic [1:0] active_ch,
  output logic       busy
);

  localparam int c_DIV_W  = $clog2(STEP_DIV);
  localparam int c_HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(STEP_DIV - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
  localparam logic [8:0]          c_STEP9     = 9'(STEP);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_UP   = 3'd1;
  localparam logic [2:0] c_HOLD = 3'd2;
  localparam logic [2:0] c_DOWN = 3'd3;
  localparam logic [2:0] c_NEXT = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [7:0]          r_pwm_cnt;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [7:0]          r_bright [3];
  logic [1:0]          r_active_ch;
  logic [1:0]          w_ch_nxt;
  logic [2:0]          r_led;
  logic [2:0]          w_led_nxt;
  logic                w_busy;
  logic                w_count_en;
  logic                w_tick;
  logic [7:0]          w_cur;
  logic [8:0]          w_sum;
  logic [8:0]          w_diff;
  logic [7:0]          w_up_val;
  logic [7:0]          w_dn_val;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; every fade transition is aligned to a tick
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (en) begin
          w_state_nxt = c_UP;
        end
      end
      c_UP: begin
        if (w_tick && (w_up_val == 8'hFF)) begin
          w_state_nxt = c_HOLD;
        end
      end
      c_HOLD: begin
        if (w_tick && (r_hold_cnt == c_HOLD_LAST)) begin
          w_state_nxt = c_DOWN;
        end
      end
      c_DOWN: begin
        if (w_tick && (w_dn_val == 8'h00)) begin
          w_state_nxt = c_NEXT;
        end
      end
      c_NEXT: begin
        w_state_nxt = en ? c_UP : c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_busy     = 1'b1;
    w_count_en = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_busy = 1'b0;
      end
      c_UP, c_HOLD, c_DOWN: begin
        w_count_en = 1'b1;
      end
      default: begin
        w_busy     = 1'b1;
        w_count_en = 1'b0;
      end
    endcase
  end

  assign w_tick = w_count_en && (r_div_cnt == c_DIV_LAST);

  always_comb begin
    case (r_active_ch)
      2'd1:    w_cur = r_bright[1];
      2'd2:    w_cur = r_bright[2];
      default: w_cur = r_bright[0];
    endcase
  end

  // Saturating step arithmetic in 9 bits: carry clamps up, borrow clamps down
  assign w_sum    = {1'b0, w_cur} + c_STEP9;
  assign w_diff   = {1'b0, w_cur} - c_STEP9;
  assign w_up_val = w_sum[8]  ? 8'hFF : w_sum[7:0];
  assign w_dn_val = w_diff[8] ? 8'h00 : w_diff[7:0];

  assign w_ch_nxt = (r_active_ch == 2'd2) ? 2'd0 : (r_active_ch + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Divider is held at zero through NEXT, which stretches that tick gap by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (!w_count_en) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == c_DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + c_DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state != c_HOLD) begin
      r_hold_cnt <= '0;
    end else if (w_tick) begin
      r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_bright[i] <= 8'd0;
      end
    end else if (r_state == c_IDLE) begin
      for (int i = 0; i < 3; i++) begin
        r_bright[i] <= 8'd0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (r_active_ch == 2'(i)) begin
          if (r_state == c_UP) begin
            r_bright[i] <= w_up_val;
          end else if (r_state == c_DOWN) begin
            r_bright[i] <= w_dn_val;
          end
        end
      end
    end
  end

  // A stop at NEXT returns straight to channel 0, matching the IDLE value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_ch <= 2'd0;
    end else if (r_state == c_NEXT) begin
      r_active_ch <= en ? w_ch_nxt : 2'd0;
    end else if (r_state == c_IDLE) begin
      r_active_ch <= 2'd0;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign w_led_nxt[gi] = (r_pwm_cnt < r_bright[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 3'b000;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign led       = r_led;
  assign active_ch = r_active_ch;
  assign busy      = w_busy;

endmodule
`default_nettype wire
